// File: rtl/gdp_pkg.sv
// gdp_pkg: shared defaults, derived widths and saturation helpers for the
// streaming Gaussian distance scorer (gdp_stream and gdp_sat_acc).
//   DEF_DW / DEF_ACC_W / DEF_SCALE_SHIFT : default parameter values
//   DIFF_W / SQ_W / PROD_W               : derived widths for the defaults
//   sat_u / sat_s                        : unsigned / signed clamps to w bits
// The clamps work on a fixed SAT_W-bit container so one helper serves every
// width; callers extend into SAT_W and truncate the result back.
package gdp_pkg;

    localparam int unsigned DEF_DW          = 16;
    localparam int unsigned DEF_ACC_W       = 32;
    localparam int unsigned DEF_SCALE_SHIFT = 8;

    localparam int unsigned DIFF_W = DEF_DW + 1;
    localparam int unsigned SQ_W   = 2 * DEF_DW + 1;
    localparam int unsigned PROD_W = 3 * DEF_DW + 1;

    localparam int unsigned SAT_W = 128;

    // Clamp an unsigned value to [0, 2^w - 1].
    function automatic logic [SAT_W-1:0] sat_u(input logic [SAT_W-1:0] v,
                                               input int unsigned    w);
        logic [SAT_W-1:0] hi;
        hi = (SAT_W'(1) << w) - SAT_W'(1);
        return (v > hi) ? hi : v;
    endfunction

    // Clamp a signed value to [-2^(w-1), 2^(w-1) - 1].
    function automatic logic signed [SAT_W-1:0] sat_s(input logic signed [SAT_W-1:0] v,
                                                      input int unsigned           w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_W'(1) << (w - 1)) - SAT_W'(1);
        lo = ~hi;
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/gdp_sat_acc.sv
// gdp_sat_acc: saturating accumulator stage of gdp_stream.
//   clk, reset      : clock, synchronous active-low reset (clears acc)
//   en              : pipeline advance enable; acc holds when low
//   in_valid        : beat valid; bubbles leave acc untouched
//   in_first        : restart accumulation with p instead of adding
//   p               : unsigned term to accumulate
//   acc             : registered accumulator, saturates at 2^ACC_W - 1
//   sat             : (GDP_OVERFLOW_FLAG_EN only) this beat's add saturated
module gdp_sat_acc
    import gdp_pkg::*;
#(
    parameter int unsigned ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             in_valid,
    input  logic             in_first,
    input  logic [ACC_W-1:0] p,
`ifdef GDP_OVERFLOW_FLAG_EN
    output logic             sat,
`endif
    output logic [ACC_W-1:0] acc
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W:0]   sum;

    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, p};
        acc_d = acc_q;
        if (en && in_valid) begin
            acc_d = in_first ? p : ACC_W'(sat_u(SAT_W'(sum), ACC_W));
        end
    end

`ifdef GDP_OVERFLOW_FLAG_EN
    assign sat = en && in_valid && !in_first && sum[ACC_W];
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/gdp_stream.sv
// gdp_stream: streaming Gaussian distance scorer, ln_p = k - sum((x-mean)^2*omega >> SCALE_SHIFT).
//   clk, reset          : clock, synchronous active-low reset
//   in_valid/in_ready   : component beat handshake
//   in_first/in_last    : vector delimiters; k is sampled on the first beat
//   x, mean             : signed DW-bit components
//   omega               : unsigned DW-bit weight
//   k                   : signed DW-bit state constant
//   out_valid/out_ready : result handshake; result holds until accepted
//   ln_p                : signed DW-bit saturated score
//   ovf                 : sticky per-vector saturation flag, present only
//                         when GDP_OVERFLOW_FLAG_EN is defined
// Five stages: S1 diff, S2 square, S3 scale, S4 accumulate, S5 result.
// One global enable freezes every stage while a result is stalled.
module gdp_stream
    import gdp_pkg::*;
#(
    parameter int unsigned DW          = DEF_DW,
    parameter int unsigned ACC_W       = DEF_ACC_W,
    parameter int unsigned SCALE_SHIFT = DEF_SCALE_SHIFT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_first,
    input  logic          in_last,
    input  logic [DW-1:0] x,
    input  logic [DW-1:0] mean,
    input  logic [DW-1:0] omega,
    input  logic [DW-1:0] k,
    output logic          out_valid,
    input  logic          out_ready,
`ifdef GDP_OVERFLOW_FLAG_EN
    output logic          ovf,
`endif
    output logic [DW-1:0] ln_p
);

    localparam int unsigned L_DIFF_W = DW + 1;
    localparam int unsigned L_SQ_W   = 2 * DW + 1;
    localparam int unsigned L_PROD_W = 3 * DW + 1;

    logic en;

    // k travels with each beat so back-to-back vectors keep their own k.
    logic                       s1_valid_q, s1_valid_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
    logic signed [L_DIFF_W-1:0] s1_diff_q, s1_diff_d;
    logic [DW-1:0]              s1_omega_q, s1_omega_d, s1_k_q, s1_k_d;

    logic                       s2_valid_q, s2_valid_d, s2_first_q, s2_first_d, s2_last_q, s2_last_d;
    logic [L_SQ_W-1:0]          s2_sq_q, s2_sq_d;
    logic [DW-1:0]              s2_omega_q, s2_omega_d, s2_k_q, s2_k_d;
    logic signed [2*L_DIFF_W-1:0] sq_full;

    logic                       s3_valid_q, s3_valid_d, s3_first_q, s3_first_d, s3_last_q, s3_last_d;
    logic [ACC_W-1:0]           s3_p_q, s3_p_d;
    logic [DW-1:0]              s3_k_q, s3_k_d;
    logic [L_PROD_W-1:0]        prod;
    logic [SAT_W-1:0]           p_wide;

    logic                       s4_valid_q, s4_valid_d, s4_last_q, s4_last_d;
    logic [DW-1:0]              s4_k_q, s4_k_d;
    logic [ACC_W-1:0]           acc;

    logic                       out_valid_q, out_valid_d;
    logic [DW-1:0]              ln_p_q, ln_p_d;
    logic signed [ACC_W:0]      d5;
    logic signed [SAT_W-1:0]    d5_sat;

`ifdef GDP_OVERFLOW_FLAG_EN
    logic s3_sat_q, s3_sat_d, s4_ovf_q, s4_ovf_d, ovf_q, ovf_d, acc_sat;
`endif

    assign en       = !(out_valid_q && !out_ready);
    assign in_ready = en;

    // S1: difference; k latched only on a valid first beat.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_first_d = s1_first_q;
        s1_last_d  = s1_last_q;
        s1_diff_d  = s1_diff_q;
        s1_omega_d = s1_omega_q;
        s1_k_d     = s1_k_q;
        if (en) begin
            s1_valid_d = in_valid;
            s1_first_d = in_valid && in_first;
            s1_last_d  = in_valid && in_last;
            s1_diff_d  = $signed({x[DW-1], x}) - $signed({mean[DW-1], mean});
            s1_omega_d = omega;
            if (in_valid && in_first) begin
                s1_k_d = k;
            end
        end
    end

    // S2: square (always non-negative, fits in L_SQ_W).
    always_comb begin
        sq_full    = s1_diff_q * s1_diff_q;
        s2_valid_d = s2_valid_q;
        s2_first_d = s2_first_q;
        s2_last_d  = s2_last_q;
        s2_sq_d    = s2_sq_q;
        s2_omega_d = s2_omega_q;
        s2_k_d     = s2_k_q;
        if (en) begin
            s2_valid_d = s1_valid_q;
            s2_first_d = s1_first_q;
            s2_last_d  = s1_last_q;
            s2_sq_d    = L_SQ_W'($unsigned(sq_full));
            s2_omega_d = s1_omega_q;
            s2_k_d     = s1_k_q;
        end
    end

    // S3: weight, scale and clamp to the accumulator width.
    always_comb begin
        prod       = L_PROD_W'(s2_sq_q) * L_PROD_W'(s2_omega_q);
        p_wide     = sat_u(SAT_W'(prod >> SCALE_SHIFT), ACC_W);
        s3_valid_d = s3_valid_q;
        s3_first_d = s3_first_q;
        s3_last_d  = s3_last_q;
        s3_p_d     = s3_p_q;
        s3_k_d     = s3_k_q;
`ifdef GDP_OVERFLOW_FLAG_EN
        s3_sat_d   = s3_sat_q;
`endif
        if (en) begin
            s3_valid_d = s2_valid_q;
            s3_first_d = s2_first_q;
            s3_last_d  = s2_last_q;
            s3_p_d     = ACC_W'(p_wide);
            s3_k_d     = s2_k_q;
`ifdef GDP_OVERFLOW_FLAG_EN
            s3_sat_d   = s2_valid_q && (p_wide != SAT_W'(prod >> SCALE_SHIFT));
`endif
        end
    end

    // S4: accumulator plus the beat's side-band.
    gdp_sat_acc #(
        .ACC_W (ACC_W)
    ) u_acc (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .in_valid (s3_valid_q),
        .in_first (s3_first_q),
        .p        (s3_p_q),
`ifdef GDP_OVERFLOW_FLAG_EN
        .sat      (acc_sat),
`endif
        .acc      (acc)
    );

    always_comb begin
        s4_valid_d = s4_valid_q;
        s4_last_d  = s4_last_q;
        s4_k_d     = s4_k_q;
`ifdef GDP_OVERFLOW_FLAG_EN
        s4_ovf_d   = s4_ovf_q;
`endif
        if (en) begin
            s4_valid_d = s3_valid_q;
            s4_last_d  = s3_last_q;
            s4_k_d     = s3_k_q;
`ifdef GDP_OVERFLOW_FLAG_EN
            if (s3_valid_q) begin
                s4_ovf_d = (s3_first_q ? 1'b0 : s4_ovf_q) | s3_sat_q | acc_sat;
            end
`endif
        end
    end

    // S5: result register; a new result may load in the handshake cycle.
    always_comb begin
        d5          = (ACC_W + 1)'($signed(s4_k_q)) - $signed({1'b0, acc});
        d5_sat      = sat_s(SAT_W'(d5), DW);
        out_valid_d = out_valid_q;
        ln_p_d      = ln_p_q;
`ifdef GDP_OVERFLOW_FLAG_EN
        ovf_d       = ovf_q;
`endif
        if (en) begin
            out_valid_d = s4_valid_q && s4_last_q;
            if (s4_valid_q && s4_last_q) begin
                ln_p_d = DW'(d5_sat);
`ifdef GDP_OVERFLOW_FLAG_EN
                ovf_d  = s4_ovf_q | (d5_sat != SAT_W'(d5));
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_diff_q   <= '0;
            s1_omega_q  <= '0;
            s1_k_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_first_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_sq_q     <= '0;
            s2_omega_q  <= '0;
            s2_k_q      <= '0;
            s3_valid_q  <= 1'b0;
            s3_first_q  <= 1'b0;
            s3_last_q   <= 1'b0;
            s3_p_q      <= '0;
            s3_k_q      <= '0;
            s4_valid_q  <= 1'b0;
            s4_last_q   <= 1'b0;
            s4_k_q      <= '0;
            out_valid_q <= 1'b0;
            ln_p_q      <= '0;
`ifdef GDP_OVERFLOW_FLAG_EN
            s3_sat_q    <= 1'b0;
            s4_ovf_q    <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            s1_diff_q   <= s1_diff_d;
            s1_omega_q  <= s1_omega_d;
            s1_k_q      <= s1_k_d;
            s2_valid_q  <= s2_valid_d;
            s2_first_q  <= s2_first_d;
            s2_last_q   <= s2_last_d;
            s2_sq_q     <= s2_sq_d;
            s2_omega_q  <= s2_omega_d;
            s2_k_q      <= s2_k_d;
            s3_valid_q  <= s3_valid_d;
            s3_first_q  <= s3_first_d;
            s3_last_q   <= s3_last_d;
            s3_p_q      <= s3_p_d;
            s3_k_q      <= s3_k_d;
            s4_valid_q  <= s4_valid_d;
            s4_last_q   <= s4_last_d;
            s4_k_q      <= s4_k_d;
            out_valid_q <= out_valid_d;
            ln_p_q      <= ln_p_d;
`ifdef GDP_OVERFLOW_FLAG_EN
            s3_sat_q    <= s3_sat_d;
            s4_ovf_q    <= s4_ovf_d;
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign ln_p      = ln_p_q;
`ifdef GDP_OVERFLOW_FLAG_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: doc/gdp_stream.md
Name: gdp_stream

Overview:
- Parametrised streaming Gaussian distance scorer for HMM state evaluation. Next generation of the fixed 16-bit GDP unit.
- Consumes one observation component per beat: x, mean, omega, plus the state's k on the first beat.
- Accumulates the omega-scaled squared distance over a vector of arbitrary length and emits ln_p = k - acc.
- Adds valid/ready handshakes, output backpressure, widened saturating arithmetic and configurable scaling. Sits between the observation buffer and the Viterbi/state-score logic.

Parameters:
- DW, 16, width of x/mean/omega/k/ln_p.
- ACC_W, 32, accumulator width (unsigned).
- SCALE_SHIFT, 8, right shift applied to (diff^2 * omega) before accumulation.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (reset==0 at a clk edge resets).
- in_valid  in  1  component beat valid.
- in_ready  out  1  block accepts a beat when in_valid && in_ready.
- in_first  in  1  first component of a vector; k sampled on this beat.
- in_last  in  1  last component of a vector.
- x  in  DW  observation component, signed.
- mean  in  DW  mean component, signed.
- omega  in  DW  inverse-variance weight, unsigned.
- k  in  DW  state constant, signed; used only on the in_first beat.
- out_valid  out  1  ln_p valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- ln_p  out  DW  signed score.

Behaviour:
- Reset (reset==0) behaviour:
  - Clears all stage valids, the accumulator and the held k.
  - out_valid=0, ln_p=0, in_ready=1 in the cycle after.
  - Applying reset mid-vector discards the partial vector.
- Global advance enable: en = !(out_valid && !out_ready). in_ready = en. All pipeline registers hold when en=0.
- Stage S1: diff = x - mean, DW+1 bits signed. Registers diff, omega, first, last, valid. k is registered when first.
- Stage S2: sq = diff*diff, 2DW+1 bits unsigned.
- Stage S3: p = (sq*omega) >> SCALE_SHIFT, saturated to ACC_W bits unsigned.
- Stage S4: acc = first ? p : sat(acc + p), unsigned, saturating at 2^ACC_W-1.
- Stage S5: when the S4 beat is valid && last, ln_p = sat_DW(k - acc) and out_valid=1.
  - The difference is computed in ACC_W+1 bits signed.
  - Saturation range is [-2^(DW-1), 2^(DW-1)-1].
- Latency: out_valid is high in the 5th cycle after the cycle in which the last beat was accepted, with no stalls. Throughput is one beat per cycle.
- out_valid/ln_p hold stable until the handshake completes. out_valid clears on the handshake unless a new result loads in the same cycle.
- Boundary conditions:
  - in_first && in_last on the same beat: a 1-component vector, result = sat(k - p).
  - in_first mid-vector: restarts accumulation; the partial vector is silently dropped.
  - Beat without a prior in_first since reset: accumulates onto acc=0 with k=0.
  - in_valid=0 bubbles propagate and do not disturb acc.
  - Back-to-back vectors (last followed immediately by first) are legal with no bubble.

Optional Feature:
- Macro: GDP_OVERFLOW_FLAG_EN.
- When defined:
  - Adds output port ovf (1 bit, reset 0).
  - ovf is sticky across a vector: set if any S3 saturation, S4 saturation or S5 saturation occurred in that vector.
  - ovf is presented with, and held alongside, out_valid/ln_p. It clears at each new first beat.
- When undefined: the port and logic are absent and saturation is silent.

Decomposition:
- Shared package gdp_pkg:
  - Default DW/ACC_W/SCALE_SHIFT localparams.
  - Saturation helper functions (unsigned clamp, signed clamp).
  - Derived widths: DIFF_W=DW+1, SQ_W=2DW+1, PROD_W=3DW+1.
- One natural sub-module: gdp_sat_acc (the S4 saturating accumulator with first-restart and enable).

Test Plan (DW=16, ACC_W=32, SCALE_SHIFT=8):
- 1-component vector x=10, mean=4, omega=256, k=100 -> ln_p=64 exactly 5 cycles after acceptance; ovf=0.
- 3 components (3,1,256), (0,2,512), (5,5,256), k=50 -> acc=4+8+0=12, ln_p=38; back-to-back repeat gives 38 again with no bubble.
- x=32767, mean=-32768, omega=65535, k=0 -> acc saturates at 0xFFFFFFFF, ln_p=-32768, ovf=1.
- Two 1-beat vectors (ln_p 64 and 38) with out_ready=0 for 10 cycles -> in_ready drops, ln_p holds 64 stable; on release, 64 then 38, none lost or duplicated.
- Reset driven low after 2 of 3 beats, then a fresh vector x=2, mean=0, omega=256, k=10 -> only ln_p=6 is emitted.
- in_first reasserted mid-vector after 1 beat of a 3-beat vector -> only the restarted vector's result is emitted.
